a2_writeback: RTL and testbench
===============================

// Module: a2_writeback
// PURPOSE
//  Write-back (WB) stage of the 8-bit pipelined datapath; consumes EX outputs.
//  Holds the EX/WB pipeline register and selects write-back data (sum or sign-extended immediate).
//  Owns the 8x8 register file: writes at WB and serves the two ID-stage read ports.
//  Returns forwarded_data and EX_WB_rd to the EX forwarding unit.
// PARAMETERS
//  DATA_W    8     register / datapath width
//  ADDR_W    3     register address width
//  NUM_REGS  8     register count (2**ADDR_W)
// PORTS
//  clk             in   1       rising-edge clock
//  reset_n         in   1       asynchronous reset, active-low
//  stall           in   1       1: hold EX/WB register contents
//  flush           in   1       1: load a bubble into EX/WB (overrides stall)
//  SEtoReg_in      in   1       1: write back extended; 0: write back sum
//  WriteReg_in     in   1       register-write enable from EX
//  rd_in           in   ADDR_W  destination register from EX
//  sum_in          in   DATA_W  adder result from EX
//  extended_in     in   DATA_W  sign-extended immediate from EX
//  rs1_addr        in   ADDR_W  ID read port 1 address
//  rs2_addr        in   ADDR_W  ID read port 2 address
//  rs1_data        out  DATA_W  ID read port 1 data (combinational)
//  rs2_data        out  DATA_W  ID read port 2 data (combinational)
//  EX_WB_rd        out  ADDR_W  registered rd, to forwarding unit
//  EX_WB_WriteReg  out  1       registered WriteReg; forwarding is valid only when 1
//  forwarded_data  out  DATA_W  write-back data, to EX forwarding muxes
// BEHAVIOUR
//  - Reset (reset_n=0, async): EX/WB regs all 0 (EX_WB_rd=0, EX_WB_WriteReg=0,
//    forwarded_data=0); all NUM_REGS registers = 0. Deassert is synchronous to clk.
//  - EX/WB register, at posedge clk:
//    flush=1            -> WriteReg<=0, SEtoReg<=0, rd<=0, sum<=0, ext<=0 (bubble)
//    flush=0, stall=1   -> hold all fields
//    else               -> capture SEtoReg_in, WriteReg_in, rd_in, sum_in, extended_in
//  - forwarded_data = reg_SEtoReg ? reg_ext : reg_sum (combinational from EX/WB regs).
//  - Latency: EX inputs appear on forwarded_data/EX_WB_rd 1 cycle later; the register
//    file is updated at the following edge (2nd edge after EX presented the data).
//  - RF write, at posedge clk: if EX_WB_WriteReg=1 and stall=0, regfile[EX_WB_rd] <= forwarded_data.
//    All registers are writable (no hard-wired zero register). stall blocks the write so a
//    held instruction writes exactly once; flush does not cancel the write of the
//    instruction already in EX/WB.
//  - Reads: rs1_data = regfile[rs1_addr], rs2_data = regfile[rs2_addr], asynchronous;
//    both ports may address the same register.
//  - Arithmetic: none in this block; data passes at DATA_W bits, no truncation/extension.
//  - Reset mid-operation: pending write is discarded; the bubble state holds until the
//    first capture after reset_n rises.
// CONFIGURATION
//  RF_BYPASS_EN defined: if a write fires this cycle (EX_WB_WriteReg=1, stall=0) and
//    rsN_addr == EX_WB_rd, rsN_data = forwarded_data (write-through; ID sees the new value
//    in the same cycle).
//  RF_BYPASS_EN undefined: rsN_data returns the pre-write register contents; the
//    same-cycle hazard is resolved outside this block.
// TESTING
//  1 Reset: drive reset_n=0 mid-cycle -> outputs 0 immediately; rs1_data=rs2_data=0 for
//    every address.
//  2 Sum path: WriteReg_in=1, SEtoReg_in=0, rd_in=3, sum_in=8'h30, extended_in=8'hFE
//    -> next cycle forwarded_data=8'h30, EX_WB_rd=3; following cycle rs1_addr=3 gives 8'h30.
//  3 Ext path: SEtoReg_in=1, rd_in=0, extended_in=8'hFE, sum_in=8'h50 -> forwarded_data=8'hFE;
//    reg0=8'hFE after the write edge.
//  4 Stall/flush: capture rd=5, data 8'h11, then stall=1 for 3 cycles -> fields held,
//    reg5 not written; release -> reg5=8'h11 written once; flush=1 -> EX_WB_WriteReg=0 next cycle.
//  5 Bypass: reg2=8'h07, write 8'h44 to reg2 with rs1_addr=rs2_addr=2 in the write cycle
//    -> 8'h44 on both ports if RF_BYPASS_EN, else 8'h07; 8'h44 in both builds next cycle.
//  6 WriteReg_in=0, rd_in=6, sum_in=8'hAA -> reg6 unchanged; forwarded_data=8'hAA with
//    EX_WB_WriteReg=0.

Source files
------------

// File: rtl/a2_writeback_if.sv
// a2_writeback_if: EX-stage inputs, ID-stage register read ports and forwarding outputs
// of the write-back stage, bundled so the pipeline top connects one port per stage.
interface a2_writeback_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              stall;
    logic              flush;
    logic              SEtoReg_in;
    logic              WriteReg_in;
    logic [ADDR_W-1:0] rd_in;
    logic [DATA_W-1:0] sum_in;
    logic [DATA_W-1:0] extended_in;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [ADDR_W-1:0] EX_WB_rd;
    logic              EX_WB_WriteReg;
    logic [DATA_W-1:0] forwarded_data;

    // Pipeline side: drives EX results and ID read addresses, consumes RF data and forwarding.
    modport master (
        output stall, flush, SEtoReg_in, WriteReg_in, rd_in, sum_in, extended_in,
        output rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, EX_WB_rd, EX_WB_WriteReg, forwarded_data
    );

    modport slave (
        input  stall, flush, SEtoReg_in, WriteReg_in, rd_in, sum_in, extended_in,
        input  rs1_addr, rs2_addr,
        output rs1_data, rs2_data, EX_WB_rd, EX_WB_WriteReg, forwarded_data
    );
endinterface

// File: rtl/a2_writeback.sv
// a2_writeback: EX/WB pipeline register, write-back data select and the 8x8 register file.
// Optional macro RF_BYPASS_EN: same-cycle write-through from the WB write to the ID read ports.
module a2_writeback #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    a2_writeback_if.slave  wb
);
    logic              reg_se;
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_rd;
    logic [DATA_W-1:0] reg_sum;
    logic [DATA_W-1:0] reg_ext;
    logic [DATA_W-1:0] wb_data;
    logic              wr_fire;
    logic [DATA_W-1:0] regfile [NUM_REGS];

    // flush has priority so a bubble can be injected even while the stage is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_se  <= 1'b0;
            reg_wr  <= 1'b0;
            reg_rd  <= '0;
            reg_sum <= '0;
            reg_ext <= '0;
        end else if (wb.flush) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            reg_se  <= 1'b0;
            reg_wr  <= 1'b0;
            reg_rd  <= '0;
            reg_sum <= '0;
            reg_ext <= '0;
        end else if (!wb.stall) begin
            reg_se  <= wb.SEtoReg_in;
            reg_wr  <= wb.WriteReg_in;
            reg_rd  <= wb.rd_in;
            reg_sum <= wb.sum_in;
            reg_ext <= wb.extended_in;
        end
    end

    assign wb_data           = reg_se ? reg_ext : reg_sum;
    assign wb.forwarded_data = wb_data;
    assign wb.EX_WB_rd       = reg_rd;
    assign wb.EX_WB_WriteReg = reg_wr;

    // A stalled instruction stays in EX/WB; blocking its write makes it retire exactly once.
    assign wr_fire = reg_wr && !wb.stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the register file must read zero after reset, so it is built from
            // resettable flops rather than an inferred RAM macro.
            for (int i = 0; i < NUM_REGS; i++) begin
                regfile[i] <= '0;
            end
        end else if (wr_fire) begin
            regfile[reg_rd] <= wb_data;
        end
    end

`ifdef RF_BYPASS_EN
    assign wb.rs1_data = (wr_fire && (wb.rs1_addr == reg_rd)) ? wb_data : regfile[wb.rs1_addr];
    assign wb.rs2_data = (wr_fire && (wb.rs2_addr == reg_rd)) ? wb_data : regfile[wb.rs2_addr];
`else
    assign wb.rs1_data = regfile[wb.rs1_addr];
    assign wb.rs2_data = regfile[wb.rs2_addr];
`endif
endmodule

// File: tb/tb_a2_writeback.sv
// tb_a2_writeback: directed bench for a2_writeback; EX/WB contents tracked by a scoreboard
// queue and the register file by a reference array.
`timescale 1ns/1ps
module tb_a2_writeback;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic   clk = 1'b0;
    logic   reset_n = 1'b1;
    int     checks = 0;
    int     failures = 0;
    stage_t sb_q[$];
    stage_t cur;
    logic [DATA_W-1:0] model_rf [NUM_REGS];

    a2_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    a2_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected read-port value given the model state before the coming edge.
    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
`ifdef RF_BYPASS_EN
        if (cur.wr && !bus.stall && (a == cur.rd)) return cur.data;
`endif
        return model_rf[a];
    endfunction

    task automatic set_ex(input logic se, input logic wr, input logic [ADDR_W-1:0] rd,
                          input logic [DATA_W-1:0] sum, input logic [DATA_W-1:0] ext);
        bus.SEtoReg_in  = se;
        bus.WriteReg_in = wr;
        bus.rd_in       = rd;
        bus.sum_in      = sum;
        bus.extended_in = ext;
    endtask

    task automatic check_reg(input string tag, input logic [ADDR_W-1:0] a);
        bus.rs1_addr = a;
        bus.rs2_addr = a;
        #1;
        check({tag, "_rs1"}, bus.rs1_data, exp_read(a));
        check({tag, "_rs2"}, bus.rs2_data, exp_read(a));
    endtask

    // Predict EX/WB after the edge from the driven inputs, then compare once it happens.
    task automatic clock_edge();
        stage_t nxt;
        if (bus.flush) begin
            nxt = '0;
        end else if (bus.stall) begin
            nxt = cur;
        end else begin
            nxt.wr   = bus.WriteReg_in;
            nxt.rd   = bus.rd_in;
            nxt.data = bus.SEtoReg_in ? bus.extended_in : bus.sum_in;
        end
        sb_q.push_back(nxt);
        if (cur.wr && !bus.stall) model_rf[cur.rd] = cur.data;
        @(posedge clk);
        #1;
        cur = sb_q.pop_front();
        check("ex_wb_rd", bus.EX_WB_rd, cur.rd);
        check("ex_wb_writereg", bus.EX_WB_WriteReg, cur.wr);
        check("forwarded_data", bus.forwarded_data, cur.data);
    endtask

    // Assert reset mid-cycle, check everything cleared at once, release after two edges.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        cur = '0;
        sb_q.delete();
        for (int i = 0; i < NUM_REGS; i++) model_rf[i] = '0;
        check({tag, "_rd"}, bus.EX_WB_rd, 0);
        check({tag, "_wr"}, bus.EX_WB_WriteReg, 0);
        check({tag, "_fwd"}, bus.forwarded_data, 0);
        for (int i = 0; i < NUM_REGS; i++) begin
            bus.rs1_addr = ADDR_W'(i);
            bus.rs2_addr = ADDR_W'(NUM_REGS - 1 - i);
            #1;
            check({tag, "_rf_rs1"}, bus.rs1_data, 0);
            check({tag, "_rf_rs2"}, bus.rs2_data, 0);
        end
        set_ex(0, 0, 0, 0, 0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        set_ex(0, 0, 0, 0, 0);
        cur = '0;
        for (int i = 0; i < NUM_REGS; i++) model_rf[i] = '0;

        #3;
        do_reset("reset");
        clock_edge();

        // Sum path
        set_ex(0, 1, 3, 8'h30, 8'hFE);
        clock_edge();
        set_ex(0, 0, 0, 0, 0);
        clock_edge();
        check_reg("sum_reg3", 3);

        // Extended path into register 0 (writable)
        set_ex(1, 1, 0, 8'h50, 8'hFE);
        clock_edge();
        set_ex(0, 0, 0, 0, 0);
        clock_edge();
        check_reg("ext_reg0", 0);

        // Stall holds EX/WB and blocks the write; release writes once
        set_ex(0, 1, 5, 8'h11, 8'h99);
        clock_edge();
        bus.stall = 1'b1;
        set_ex(0, 1, 4, 8'h22, 8'h00);
        repeat (3) begin
            clock_edge();
            check_reg("stall_reg5", 5);
        end
        set_ex(0, 0, 0, 0, 0);
        bus.stall = 1'b0;
        clock_edge();
        check_reg("release_reg5", 5);

        // Flush inserts a bubble but the instruction already in EX/WB still writes
        set_ex(0, 1, 1, 8'h5A, 8'h00);
        clock_edge();
        bus.flush = 1'b1;
        set_ex(0, 1, 2, 8'h33, 8'h00);
        clock_edge();
        bus.flush = 1'b0;
        set_ex(0, 0, 0, 0, 0);
        check_reg("flush_reg1", 1);

        // Flush overrides stall; stall still blocks the pending write
        set_ex(0, 1, 4, 8'h66, 8'h00);
        clock_edge();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        clock_edge();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clock_edge();
        check_reg("flush_stall_reg4", 4);

        // Same-cycle read of the register being written
        set_ex(0, 1, 2, 8'h07, 8'h00);
        clock_edge();
        set_ex(0, 1, 2, 8'h44, 8'h00);
        clock_edge();
        set_ex(0, 0, 0, 0, 0);
        check_reg("bypass_write_cycle", 2);
        clock_edge();
        check_reg("bypass_next_cycle", 2);

        // Non-writing instruction still forwards its data
        set_ex(0, 0, 6, 8'hAA, 8'h00);
        clock_edge();
        set_ex(0, 0, 0, 0, 0);
        clock_edge();
        check_reg("nowrite_reg6", 6);

        // Back-to-back writes with varied data and both select paths
        for (int k = 0; k < 8; k++) begin
            logic [DATA_W-1:0] d;
            d = DATA_W'($urandom);
            set_ex(k[0], 1'b1, ADDR_W'($urandom_range(0, NUM_REGS - 1)), d, ~d);
            clock_edge();
        end
        set_ex(0, 0, 0, 0, 0);
        clock_edge();
        clock_edge();
        for (int i = 0; i < NUM_REGS; i++) check_reg("sweep", ADDR_W'(i));

        // Reset with a write pending in EX/WB discards it
        set_ex(0, 1, 7, 8'h77, 8'h00);
        clock_edge();
        #2;
        do_reset("midop_reset");
        clock_edge();
        check_reg("midop_reg7", 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
